// File: rtl/c64_kbd_pkg.sv
// Shared definitions for the C64 keyboard/joystick front end:
// special key codes, the host event record and the matrix sense helpers.
package c64_kbd_pkg;

    localparam logic [6:0] KEY_RESTORE     = 7'd64;
    localparam logic [6:0] KEY_SHIFTLOCK   = 7'd65;
    localparam logic [6:0] KEY_RELEASE_ALL = 7'd127;
    localparam logic [5:0] KEY_LSHIFT      = 6'o17;

    typedef struct packed {
        logic [6:0] code;
        logic       make;
    } kbd_event_t;

    // Port B sense: a closed key pulls column b low when its row a is driven low on PA.
    function automatic logic [7:0] kbd_sense_pb(input logic [63:0] eff,
                                                input logic [7:0]  pa_drv,
                                                input logic [7:0]  pb_drv,
                                                input logic [7:0]  joy);
        logic [7:0] res;
        res = pb_drv & ~joy;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                if (eff[a*8+b] && !pa_drv[a]) begin
                    res[b] = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Port A sense: the transpose of the above, rows read back through driven columns.
    function automatic logic [7:0] kbd_sense_pa(input logic [63:0] eff,
                                                input logic [7:0]  pa_drv,
                                                input logic [7:0]  pb_drv,
                                                input logic [7:0]  joy);
        logic [7:0] res;
        res = pa_drv & ~joy;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                if (eff[a*8+b] && !pb_drv[b]) begin
                    res[a] = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Small synchronous first-word-fall-through FIFO holding host key events
// until the next Phi 2 cycle can apply them.
module kbd_event_fifo
    import c64_kbd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/c64_keyboard_matrix.sv
// CIA1 keyboard/joystick front end: buffers host key events, applies one per
// Phi 2 to the 8x8 key matrix, drives RESTORE onto NMI and resolves CIA1 port inputs.
module c64_keyboard_matrix
    import c64_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int RESTORE_PULSE = 16
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [6:0] key_code,
    input  logic       key_make,
    input  logic [7:0] pa_out,
    input  logic [7:0] pb_out,
    input  logic [4:0] joy1,
    input  logic [4:0] joy2,
    output logic [7:0] pa_in,
    output logic [7:0] pb_in,
    output logic       restore_n
);

    localparam int CNT_W  = $clog2(RESTORE_PULSE + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    kbd_event_t         push_evt_s;
    kbd_event_t         pop_evt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [FCNT_W-1:0]  fifo_count_s;
    logic               push_s;
    logic               pop_s;
    logic               restore_load_s;

    logic [63:0]        matrix_r;
    logic [63:0]        matrix_next_s;
    logic               shift_lock_r;
    logic               shift_lock_next_s;
    logic [CNT_W-1:0]   restore_cnt_r;
    logic [CNT_W-1:0]   restore_cnt_next_s;
    logic               restore_n_r;
    logic [63:0]        eff_s;
    logic [7:0]         pa_res_s;
    logic [7:0]         pb_res_s;
    logic [7:0]         pa_in_r;
    logic [7:0]         pb_in_r;

    assign push_evt_s = '{code: key_code, make: key_make};
    assign key_ready  = (fifo_count_s != FCNT_W'(FIFO_DEPTH));
    assign push_s     = key_valid & ~fifo_full_s;
    assign pop_s      = phi2_p & ~fifo_empty_s;

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (push_s),
        .wdata (push_evt_s),
        .pop   (pop_s),
        .rdata (pop_evt_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign restore_load_s = pop_s & (pop_evt_s.code == KEY_RESTORE) & pop_evt_s.make;

    // Apply the popped event to the matrix and shift-lock state.
    always_comb begin
        matrix_next_s     = matrix_r;
        shift_lock_next_s = shift_lock_r;
        if (pop_s) begin
            if (pop_evt_s.code[6] == 1'b0) begin
                matrix_next_s[pop_evt_s.code[5:0]] = pop_evt_s.make;
            end else begin
                case (pop_evt_s.code)
                    KEY_SHIFTLOCK: begin
                        if (pop_evt_s.make) begin
                            shift_lock_next_s = ~shift_lock_r;
                        end else begin
                            shift_lock_next_s = shift_lock_r;
                        end
                    end
                    KEY_RELEASE_ALL: matrix_next_s = 64'd0;
                    default:         matrix_next_s = matrix_r;
                endcase
            end
        end else begin
            matrix_next_s = matrix_r;
        end
    end

    // A reload mid-pulse simply extends the low time; NMI sees only one falling edge.
    always_comb begin
        restore_cnt_next_s = restore_cnt_r;
        if (restore_load_s) begin
            restore_cnt_next_s = CNT_W'(RESTORE_PULSE);
        end else if (phi2_p && (restore_cnt_r != {CNT_W{1'b0}})) begin
            restore_cnt_next_s = restore_cnt_r - CNT_W'(1);
        end else begin
            restore_cnt_next_s = restore_cnt_r;
        end
    end

    // Key state and restore pulse registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            matrix_r      <= 64'd0;
            shift_lock_r  <= 1'b0;
            restore_cnt_r <= {CNT_W{1'b0}};
            restore_n_r   <= 1'b1;
        end else begin
            matrix_r      <= matrix_next_s;
            shift_lock_r  <= shift_lock_next_s;
            restore_cnt_r <= restore_cnt_next_s;
            restore_n_r   <= (restore_cnt_next_s == {CNT_W{1'b0}});
        end
    end

    // Shift lock is wired in parallel with left shift.
    always_comb begin
        eff_s                      = matrix_r;
        eff_s[KEY_LSHIFT]          = matrix_r[KEY_LSHIFT] | shift_lock_r;
        pb_res_s = kbd_sense_pb(eff_s, pa_out, pb_out, {3'b000, joy1});
        pa_res_s = kbd_sense_pa(eff_s, pa_out, pb_out, {3'b000, joy2});
    end

    // Port inputs are sampled once per Phi 2 so the CPU sees a stable value.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pa_in_r <= 8'hFF;
            pb_in_r <= 8'hFF;
        end else if (phi2_p) begin
            pa_in_r <= pa_res_s;
            pb_in_r <= pb_res_s;
        end
    end

    assign pa_in     = pa_in_r;
    assign pb_in     = pb_in_r;
    assign restore_n = restore_n_r;

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Directed self-checking bench for c64_keyboard_matrix: key matrix, FIFO
// backpressure, RESTORE pulse, shift lock, release-all and joysticks.
module tb_c64_keyboard_matrix;

    logic       clk = 1'b0;
    logic       res_n;
    logic       phi2_p;
    logic       key_valid;
    logic       key_ready;
    logic [6:0] key_code;
    logic       key_make;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [4:0] joy1;
    logic [4:0] joy2;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic       restore_n;

    int num_checks = 0;
    int num_fails  = 0;
    int k;

    always #5 clk = ~clk;

    c64_keyboard_matrix #(
        .FIFO_DEPTH    (4),
        .RESTORE_PULSE (16)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .phi2_p    (phi2_p),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_make  (key_make),
        .pa_out    (pa_out),
        .pb_out    (pb_out),
        .joy1      (joy1),
        .joy2      (joy2),
        .pa_in     (pa_in),
        .pb_in     (pb_in),
        .restore_n (restore_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic phi2_tick();
        phi2_p = 1'b1;
        clk_step();
        phi2_p = 1'b0;
        clk_step();
    endtask

    task automatic push_event(input logic [6:0] code, input logic make);
        bit done;
        done      = 1'b0;
        key_code  = code;
        key_make  = make;
        key_valid = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            if (key_ready) done = 1'b1;
            clk_step();
        end
        key_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        res_n = 1'b0; phi2_p = 1'b0; key_valid = 1'b0; key_code = 7'd0; key_make = 1'b0;
        pa_out = 8'hFE; pb_out = 8'hFF; joy1 = 5'd0; joy2 = 5'd0;
        clk_step();
        clk_step();
        check("rst_pa_in", pa_in, 8'hFF);
        check("rst_pb_in", pb_in, 8'hFF);
        check("rst_restore_n", restore_n, 1'b1);
        check("rst_key_ready", key_ready, 1'b1);
        res_n = 1'b1;
        clk_step();

        // Idle keyboard, PA0 driven
        phi2_tick();
        check("idle_pb_in", pb_in, 8'hFF);
        check("idle_pa_in", pa_in, 8'hFE);
        check("idle_restore_n", restore_n, 1'b1);
        check("idle_key_ready", key_ready, 1'b1);

        // Single key 1/3 with one phi2 of latency
        pa_out = 8'hFD;
        push_event(7'o13, 1'b1);
        phi2_tick();
        check("key13_latency", pb_in, 8'hFF);
        phi2_tick();
        check("key13_make_pb", pb_in, 8'hF7);
        check("key13_make_pa", pa_in, 8'hFD);
        push_event(7'o13, 1'b0);
        phi2_tick();
        check("key13_break_latency", pb_in, 8'hF7);
        phi2_tick();
        check("key13_break", pb_in, 8'hFF);

        // FIFO fill with phi2 stopped
        push_event(7'o10, 1'b1);
        push_event(7'o11, 1'b1);
        push_event(7'o10, 1'b0);
        push_event(7'o11, 1'b0);
        check("fifo_full_ready", key_ready, 1'b0);
        key_code = 7'o12; key_make = 1'b1; key_valid = 1'b1;
        clk_step(); clk_step(); clk_step();
        check("fifo_stall_ready", key_ready, 1'b0);
        phi2_p = 1'b1;
        clk_step();
        phi2_p = 1'b0;
        check("fifo_ready_after_pop", key_ready, 1'b1);
        clk_step();
        key_valid = 1'b0;
        check("fifo_refill_ready", key_ready, 1'b0);
        phi2_tick(); check("order_b", pb_in, 8'hFE);
        phi2_tick(); check("order_c", pb_in, 8'hFC);
        phi2_tick(); check("order_d", pb_in, 8'hFD);
        phi2_tick(); check("order_e", pb_in, 8'hFF);
        phi2_tick(); check("order_f", pb_in, 8'hFB);
        push_event(7'o12, 1'b0);
        phi2_tick(); phi2_tick();
        check("key12_release", pb_in, 8'hFF);

        // RESTORE pulse width
        push_event(7'd64, 1'b1);
        phi2_tick();
        check("restore_low_at_apply", restore_n, 1'b0);
        k = 0;
        while (restore_n == 1'b0 && k < 60) begin phi2_tick(); k++; end
        check("restore_width", k, 16);

        // RESTORE reload at cycle 10 extends the pulse
        push_event(7'd64, 1'b1);
        phi2_tick();
        for (int i = 0; i < 9; i++) phi2_tick();
        check("restore_still_low", restore_n, 1'b0);
        push_event(7'd64, 1'b1);
        phi2_tick();
        k = 10;
        while (restore_n == 1'b0 && k < 80) begin phi2_tick(); k++; end
        check("restore_extended_width", k, 26);

        // RESTORE break ignored
        push_event(7'd64, 1'b0);
        phi2_tick();
        check("restore_break_ignored", restore_n, 1'b1);

        // Reset mid-pulse
        push_event(7'd64, 1'b1);
        phi2_tick(); phi2_tick(); phi2_tick();
        check("midpulse_low", restore_n, 1'b0);
        res_n = 1'b0;
        #1;
        check("midpulse_rst_restore_n", restore_n, 1'b1);
        check("midpulse_rst_pb_in", pb_in, 8'hFF);
        check("midpulse_rst_key_ready", key_ready, 1'b1);
        clk_step();
        res_n = 1'b1;
        clk_step();
        phi2_tick();
        check("post_rst_restore_n", restore_n, 1'b1);

        // Shift lock toggling, break ignored
        pa_out = 8'hFD;
        push_event(7'd65, 1'b1);
        phi2_tick(); phi2_tick();
        check("shiftlock_on", pb_in, 8'h7F);
        push_event(7'd65, 1'b0);
        phi2_tick(); phi2_tick();
        check("shiftlock_break_ignored", pb_in, 8'h7F);
        push_event(7'd65, 1'b1);
        phi2_tick(); phi2_tick();
        check("shiftlock_off", pb_in, 8'hFF);

        // Release-all clears keys but leaves shift lock
        push_event(7'd65, 1'b1);
        push_event(7'o12, 1'b1);
        phi2_tick(); phi2_tick(); phi2_tick();
        check("lock_plus_key12", pb_in, 8'h7B);
        push_event(7'd127, 1'b1);
        phi2_tick(); phi2_tick();
        check("release_all", pb_in, 8'h7F);
        push_event(7'd70, 1'b1);
        phi2_tick(); phi2_tick();
        check("unused_code", pb_in, 8'h7F);
        push_event(7'd65, 1'b1);
        phi2_tick(); phi2_tick();
        check("shiftlock_cleared", pb_in, 8'hFF);

        // Joysticks alone and combined with a key
        pa_out = 8'hFF; pb_out = 8'hFF; joy1 = 5'b10000;
        phi2_tick();
        check("joy1_pb_in", pb_in, 8'hEF);
        check("joy1_pa_in", pa_in, 8'hFF);
        joy2 = 5'b00001;
        phi2_tick();
        check("joy2_pa_in", pa_in, 8'hFE);
        push_event(7'o13, 1'b1);
        phi2_tick();
        pa_out = 8'hFD;
        phi2_tick();
        check("joy_key_pb_in", pb_in, 8'hE7);
        check("joy_key_pa_in", pa_in, 8'hFC);
        pa_out = 8'hFF; pb_out = 8'hF7;
        phi2_tick();
        check("joy_key_rev_pa_in", pa_in, 8'hFC);
        check("joy_key_rev_pb_in", pb_in, 8'hE7);

        // No phi2 means outputs hold
        pa_out = 8'h00; pb_out = 8'hFF; joy1 = 5'd0; joy2 = 5'd0;
        clk_step(); clk_step(); clk_step();
        check("hold_pa_in", pa_in, 8'hFC);
        check("hold_pb_in", pb_in, 8'hE7);
        phi2_tick();
        check("update_pa_in", pa_in, 8'h00);
        check("update_pb_in", pb_in, 8'hF7);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
